axi_stream_packet_if: RTL and testbench

Zero-latency AXI4-Stream packet pass-through with position tracking. It forwards one stream unchanged and monitors the handshakes to report:
- the word index within the current packet;
- whether a queried packet byte offset has been reached;
- the valid byte count of the current word;
- a sticky per-packet error.

Stream-editing blocks such as byte inserters and removers place it in front of their output to decide when header/padding boundaries fall.

---
 rtl/axi_stream_packet_pkg.sv | 36 +++
 rtl/axis_keep_popcount.sv | 18 +
 rtl/axi_stream_packet_if.sv | 146 ++++++++++++++
 tb/tb_axi_stream_packet_if.sv | 390 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_stream_packet_pkg.sv
// Shared helpers for the AXI4-Stream packet position tracker: width calculations and the
// tuser pack/unpack convention {error at bit UW-1, byte count in bits UW-2:0, 0 meaning BPW}.
package axi_stream_packet_pkg;

    // Width of a byte-count field able to hold 0..bpw.
    function automatic int unsigned calc_uw(input int unsigned bpw);
        return $clog2(bpw + 1);
    endfunction

    // Width of a packet byte offset able to hold 0..max_bytes.
    function automatic int unsigned calc_pw(input int unsigned max_bytes);
        return $clog2(max_bytes + 1);
    endfunction

    // Build a tuser value; a full word is encoded as count 0.
    function automatic logic [31:0] uwrite(input logic error, input int unsigned bytes,
                                           input int unsigned uw, input int unsigned bpw);
        logic [31:0] cnt;
        cnt = (bytes >= bpw) ? 32'd0 : bytes;
        return cnt | (32'(error) << (uw - 1));
    endfunction

    function automatic logic get_error(input logic [31:0] tuser, input int unsigned uw);
        logic [31:0] sh;
        sh = tuser >> (uw - 1);
        return sh[0];
    endfunction

    function automatic int unsigned get_bytes(input logic [31:0] tuser, input int unsigned uw,
                                              input int unsigned bpw);
        int unsigned cnt;
        cnt = tuser & ((32'd1 << (uw - 1)) - 32'd1);
        return (cnt == 0) ? bpw : cnt;
    endfunction

endpackage

// File: rtl/axis_keep_popcount.sv
// Counts the set bits of a tkeep vector to give the number of valid bytes in a word.
module axis_keep_popcount #(
    parameter int unsigned BPW = 8,
    parameter int unsigned CW  = $clog2(BPW + 1)
) (
    input  logic [BPW-1:0] keep_i,
    output logic [CW-1:0]  count_o
);

    // Sum of the individual keep bits.
    always_comb begin
        count_o = '0;
        for (int i = 0; i < BPW; i++) begin
            count_o = count_o + CW'(keep_i[i]);
        end
    end

endmodule

// File: rtl/axi_stream_packet_if.sv
// Zero-latency AXI4-Stream pass-through that tracks the word position inside the current
// packet, the valid byte count of the current word and a sticky per-packet error flag.
// Optional feature: define AXIS_PKT_OVERFLOW_CHECK_EN to build the word-count overflow flag
// and its simulation check; otherwise overflow is tied low.
module axi_stream_packet_if
    import axi_stream_packet_pkg::*;
#(
    parameter int unsigned DATA_WIDTH       = 64,
    parameter int unsigned USER_WIDTH       = 4,
    parameter int unsigned TKEEP            = 1,
    parameter int unsigned MAX_PACKET_BYTES = 16384,
    localparam int unsigned BPW             = DATA_WIDTH / 8,
    localparam int unsigned UW              = calc_uw(BPW),
    localparam int unsigned PW              = calc_pw(MAX_PACKET_BYTES)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [USER_WIDTH-1:0] s_tuser,
    input  logic [BPW-1:0]        s_tkeep,
    input  logic                  s_tlast,
    input  logic                  s_tvalid,
    output logic                  s_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic [USER_WIDTH-1:0] m_tuser,
    output logic [BPW-1:0]        m_tkeep,
    output logic                  m_tlast,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    input  logic [PW-1:0]         query_byte,
    output logic                  reached,
    output logic [PW-1:0]         word_count,
    output logic [UW-1:0]         cur_bytes,
    output logic                  pkt_error,
    output logic                  overflow
);

    localparam int unsigned   SatWords = MAX_PACKET_BYTES / BPW;
    localparam logic [PW-1:0] WordSat  = PW'(SatWords);
    localparam logic [PW:0]   BpwExt   = (PW + 1)'(BPW);
    localparam logic [UW-1:0] BpwU     = UW'(BPW);

    logic          xfer;
    logic [PW-1:0] word_count_q, word_count_d;
    logic          err_q, err_d;
    logic [PW:0]   end_byte;
    logic [UW-1:0] last_bytes;

    assign m_tdata  = s_tdata;
    assign m_tuser  = s_tuser;
    assign m_tkeep  = s_tkeep;
    assign m_tlast  = s_tlast;
    assign m_tvalid = s_tvalid;
    assign s_tready = m_tready;

    assign xfer = s_tvalid & m_tready;

    // One byte past the end of the current word; one extra bit so it never wraps.
    assign end_byte   = ({1'b0, word_count_q} + (PW + 1)'(1)) * BpwExt;
    assign reached    = {1'b0, query_byte} < end_byte;
    assign word_count = word_count_q;
    assign pkt_error  = get_error(32'(s_tuser), UW) | err_q;

    if (TKEEP != 0) begin : g_keep
        axis_keep_popcount #(
            .BPW(BPW),
            .CW (UW)
        ) u_popcount (
            .keep_i (s_tkeep),
            .count_o(last_bytes)
        );
    end else begin : g_user
        assign last_bytes = UW'(get_bytes(32'(s_tuser), UW, BPW));
    end

    // Only the last word of a packet can be partial.
    assign cur_bytes = s_tlast ? last_bytes : BpwU;

    // Next position/error state; a last-word transfer wins over a simultaneous error set.
    always_comb begin
        word_count_d = word_count_q;
        err_d        = err_q;
        if (xfer) begin
            if (s_tlast) begin
                word_count_d = '0;
                err_d        = 1'b0;
            end else begin
                err_d = pkt_error;
                if (word_count_q != WordSat) begin
                    word_count_d = word_count_q + PW'(1);
                end
            end
        end
    end

    // Position and error registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            word_count_q <= '0;
            err_q        <= 1'b0;
        end else begin
            word_count_q <= word_count_d;
            err_q        <= err_d;
        end
    end

`ifdef AXIS_PKT_OVERFLOW_CHECK_EN
    logic ovf_q, ovf_d;
    logic sat_push;

    // A non-last word accepted while the count is already pinned at its maximum.
    assign sat_push = xfer & ~s_tlast & (word_count_q == WordSat);

    // Sticky overflow until the packet ends.
    always_comb begin
        ovf_d = ovf_q;
        if (xfer & s_tlast) begin
            ovf_d = 1'b0;
        end else if (sat_push) begin
            ovf_d = 1'b1;
        end
    end

    // Overflow register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;

    // Simulation check for packets longer than MAX_PACKET_BYTES.
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!sat_push)
            else $warning("axi_stream_packet_if: packet exceeds MAX_PACKET_BYTES");
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_packet_if.sv
// Directed bench for axi_stream_packet_if: a TKEEP=1 instance (large packets) and a TKEEP=0
// instance with MAX_PACKET_BYTES=16 share one 32-bit input stream.
module tb_axi_stream_packet_if;

    logic        clk;
    logic        rst;
    logic [31:0] s_tdata;
    logic [3:0]  s_tuser;
    logic [3:0]  s_tkeep;
    logic        s_tlast;
    logic        s_tvalid;
    logic        m_tready;
    logic [14:0] qk;
    logic [4:0]  qu;

    logic        k_s_tready, k_m_tlast, k_m_tvalid, k_reached, k_pkt_error, k_overflow;
    logic [31:0] k_m_tdata;
    logic [3:0]  k_m_tuser, k_m_tkeep;
    logic [14:0] k_wc;
    logic [2:0]  k_cur;

    logic        u_s_tready, u_m_tlast, u_m_tvalid, u_reached, u_pkt_error, u_overflow;
    logic [31:0] u_m_tdata;
    logic [3:0]  u_m_tuser, u_m_tkeep;
    logic [4:0]  u_wc;
    logic [2:0]  u_cur;

    int checks;
    int failures;

    axi_stream_packet_if #(
        .DATA_WIDTH      (32),
        .USER_WIDTH      (4),
        .TKEEP           (1),
        .MAX_PACKET_BYTES(16384)
    ) u_dut_keep (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tuser   (s_tuser),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (k_s_tready),
        .m_tdata   (k_m_tdata),
        .m_tuser   (k_m_tuser),
        .m_tkeep   (k_m_tkeep),
        .m_tlast   (k_m_tlast),
        .m_tvalid  (k_m_tvalid),
        .m_tready  (m_tready),
        .query_byte(qk),
        .reached   (k_reached),
        .word_count(k_wc),
        .cur_bytes (k_cur),
        .pkt_error (k_pkt_error),
        .overflow  (k_overflow)
    );

    axi_stream_packet_if #(
        .DATA_WIDTH      (32),
        .USER_WIDTH      (4),
        .TKEEP           (0),
        .MAX_PACKET_BYTES(16)
    ) u_dut_user (
        .clk       (clk),
        .rst       (rst),
        .s_tdata   (s_tdata),
        .s_tuser   (s_tuser),
        .s_tkeep   (s_tkeep),
        .s_tlast   (s_tlast),
        .s_tvalid  (s_tvalid),
        .s_tready  (u_s_tready),
        .m_tdata   (u_m_tdata),
        .m_tuser   (u_m_tuser),
        .m_tkeep   (u_m_tkeep),
        .m_tlast   (u_m_tlast),
        .m_tvalid  (u_m_tvalid),
        .m_tready  (m_tready),
        .query_byte(qu),
        .reached   (u_reached),
        .word_count(u_wc),
        .cur_bytes (u_cur),
        .pkt_error (u_pkt_error),
        .overflow  (u_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic put(input logic [31:0] d, input logic [3:0] k, input logic [3:0] u,
                       input logic l, input logic v);
        s_tdata  = d;
        s_tkeep  = k;
        s_tuser  = u;
        s_tlast  = l;
        s_tvalid = v;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        m_tready = 1'b1;
        qk       = 15'd3;
        qu       = 5'd4;
        put(32'h0, 4'hF, 4'b0100, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (k_wc !== 15'd0) begin
            failures++; $display("FAIL reset_k_wc got=%0d exp=0", k_wc);
        end
        checks++;
        if (u_wc !== 5'd0) begin
            failures++; $display("FAIL reset_u_wc got=%0d exp=0", u_wc);
        end
        checks++;
        if (k_reached !== 1'b1) begin
            failures++; $display("FAIL reset_k_reached_q3 got=%b exp=1", k_reached);
        end
        checks++;
        if (u_reached !== 1'b0) begin
            failures++; $display("FAIL reset_u_reached_q4 got=%b exp=0", u_reached);
        end
        checks++;
        if (k_pkt_error !== 1'b1) begin
            failures++; $display("FAIL reset_k_pkt_error got=%b exp=1", k_pkt_error);
        end
        checks++;
        if (k_overflow !== 1'b0 || u_overflow !== 1'b0) begin
            failures++; $display("FAIL reset_overflow got=%b%b exp=00", k_overflow, u_overflow);
        end
        qk = 15'd4;
        #1;
        checks++;
        if (k_reached !== 1'b0) begin
            failures++; $display("FAIL reset_k_reached_q4 got=%b exp=0", k_reached);
        end
        put(32'h0, 4'hF, 4'h0, 1'b0, 1'b0);
        #1 rst = 1'b1;
        step();
    endtask

    task automatic test_basic();
        logic [31:0] dat [3] = '{32'hA0A0_0000, 32'hA1A1_0001, 32'hA2A2_0002};
        logic [3:0]  kp  [3] = '{4'hF, 4'hF, 4'h3};
        logic [14:0] ewc [3] = '{15'd0, 15'd1, 15'd2};
        logic        erc [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0]  ekc [3] = '{3'd4, 3'd4, 3'd2};
        qk       = 15'd6;
        qu       = 5'd6;
        m_tready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            put(dat[i], kp[i], 4'h0, (i == 2), 1'b1);
            @(negedge clk);
            checks++;
            if (k_wc !== ewc[i]) begin
                failures++; $display("FAIL basic_wc[%0d] got=%0d exp=%0d", i, k_wc, ewc[i]);
            end
            checks++;
            if (k_reached !== erc[i]) begin
                failures++;
                $display("FAIL basic_reached[%0d] got=%b exp=%b", i, k_reached, erc[i]);
            end
            checks++;
            if (k_cur !== ekc[i]) begin
                failures++; $display("FAIL basic_k_cur[%0d] got=%0d exp=%0d", i, k_cur, ekc[i]);
            end
            checks++;
            if (u_cur !== 3'd4) begin
                failures++; $display("FAIL basic_u_cur[%0d] got=%0d exp=4", i, u_cur);
            end
            checks++;
            if (k_m_tdata !== dat[i] || k_m_tlast !== (i == 2)) begin
                failures++;
                $display("FAIL basic_fwd[%0d] got=%h/%b exp=%h/%b", i, k_m_tdata, k_m_tlast,
                         dat[i], (i == 2));
            end
            step();
        end
        put(32'h0, 4'hF, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (k_wc !== 15'd0 || u_wc !== 5'd0) begin
            failures++; $display("FAIL basic_wc_after_last got=%0d/%0d exp=0/0", k_wc, u_wc);
        end
        step();
    endtask

    task automatic test_backpressure();
        logic [31:0] dat [3] = '{32'hB0B0_0000, 32'hB1B1_0001, 32'hB2B2_0002};
        logic [14:0] ewc [3] = '{15'd0, 15'd1, 15'd2};
        for (int c = 0; c < 6; c++) begin
            int w;
            w        = c / 2;
            m_tready = (c % 2 == 1);
            put(dat[w], 4'hF, 4'h0, (w == 2), 1'b1);
            @(negedge clk);
            checks++;
            if (k_wc !== ewc[w]) begin
                failures++; $display("FAIL bp_wc[c%0d] got=%0d exp=%0d", c, k_wc, ewc[w]);
            end
            checks++;
            if (k_s_tready !== (c % 2 == 1)) begin
                failures++;
                $display("FAIL bp_tready[c%0d] got=%b exp=%b", c, k_s_tready, (c % 2 == 1));
            end
            checks++;
            if (k_m_tdata !== dat[w] || k_m_tvalid !== 1'b1) begin
                failures++;
                $display("FAIL bp_fwd[c%0d] got=%h/%b exp=%h/1", c, k_m_tdata, k_m_tvalid,
                         dat[w]);
            end
            step();
        end
        m_tready = 1'b1;
        put(32'h0, 4'hF, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (k_wc !== 15'd0) begin
            failures++; $display("FAIL bp_wc_after_last got=%0d exp=0", k_wc);
        end
        step();
    endtask

    task automatic test_tuser_bytes();
        logic [3:0] us  [3] = '{4'b0011, 4'b0000, 4'b0011};
        logic [3:0] kp  [3] = '{4'hF, 4'b0111, 4'b0001};
        logic       ls  [3] = '{1'b0, 1'b1, 1'b1};
        logic [2:0] euc [3] = '{3'd4, 3'd4, 3'd3};
        logic [2:0] ekc [3] = '{3'd4, 3'd3, 3'd1};
        logic [4:0] ewc [3] = '{5'd0, 5'd1, 5'd0};
        for (int i = 0; i < 3; i++) begin
            put(32'hC000_0000 + 32'(i), kp[i], us[i], ls[i], 1'b1);
            @(negedge clk);
            checks++;
            if (u_cur !== euc[i]) begin
                failures++; $display("FAIL tuser_u_cur[%0d] got=%0d exp=%0d", i, u_cur, euc[i]);
            end
            checks++;
            if (k_cur !== ekc[i]) begin
                failures++; $display("FAIL tuser_k_cur[%0d] got=%0d exp=%0d", i, k_cur, ekc[i]);
            end
            checks++;
            if (u_wc !== ewc[i] || u_pkt_error !== 1'b0) begin
                failures++;
                $display("FAIL tuser_wc_err[%0d] got=%0d/%b exp=%0d/0", i, u_wc, u_pkt_error,
                         ewc[i]);
            end
            step();
        end
        put(32'h0, 4'hF, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (u_wc !== 5'd0 || k_wc !== 15'd0) begin
            failures++; $display("FAIL one_word_pkt_wc got=%0d/%0d exp=0/0", u_wc, k_wc);
        end
        step();
    endtask

    task automatic test_error();
        logic [3:0] us  [5] = '{4'h0, 4'b0100, 4'h0, 4'h0, 4'h0};
        logic       ls  [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic       ee  [5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 5; i++) begin
            put(32'hE000_0000 + 32'(i), 4'hF, us[i], ls[i], 1'b1);
            @(negedge clk);
            checks++;
            if (k_pkt_error !== ee[i] || u_pkt_error !== ee[i]) begin
                failures++;
                $display("FAIL err_word[%0d] got=%b/%b exp=%b", i, k_pkt_error, u_pkt_error,
                         ee[i]);
            end
            step();
        end
    endtask

    task automatic test_async_reset();
        qk = 15'd6;
        for (int i = 0; i < 3; i++) begin
            put(32'hD000_0000 + 32'(i), 4'hF, 4'b0100, 1'b0, 1'b1);
            step();
        end
        put(32'h0, 4'hF, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (k_wc !== 15'd3 || u_wc !== 5'd3 || k_pkt_error !== 1'b1) begin
            failures++;
            $display("FAIL arst_before got=%0d/%0d/%b exp=3/3/1", k_wc, u_wc, k_pkt_error);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if (k_wc !== 15'd0 || u_wc !== 5'd0 || k_pkt_error !== 1'b0) begin
            failures++;
            $display("FAIL arst_during got=%0d/%0d/%b exp=0/0/0", k_wc, u_wc, k_pkt_error);
        end
        #1 rst = 1'b1;
        step();
        put(32'hD100_0000, 4'hF, 4'h0, 1'b0, 1'b1);
        @(negedge clk);
        checks++;
        if (k_wc !== 15'd0 || k_reached !== 1'b0) begin
            failures++; $display("FAIL arst_word0 got=%0d/%b exp=0/0", k_wc, k_reached);
        end
        step();
        put(32'hD100_0001, 4'hF, 4'h0, 1'b1, 1'b1);
        @(negedge clk);
        checks++;
        if (k_wc !== 15'd1 || k_reached !== 1'b1) begin
            failures++; $display("FAIL arst_word1 got=%0d/%b exp=1/1", k_wc, k_reached);
        end
        step();
    endtask

    task automatic test_saturation();
        logic [4:0]  euw [6] = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd4};
        logic        eur [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [14:0] ekw [6] = '{15'd0, 15'd1, 15'd2, 15'd3, 15'd4, 15'd5};
`ifdef AXIS_PKT_OVERFLOW_CHECK_EN
        logic        eov [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
        logic        eov [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
        qu = 5'd19;
        for (int i = 0; i < 6; i++) begin
            put(32'h5A00_0000 + 32'(i), 4'hF, 4'h0, (i == 5), 1'b1);
            @(negedge clk);
            checks++;
            if (u_wc !== euw[i]) begin
                failures++; $display("FAIL sat_u_wc[%0d] got=%0d exp=%0d", i, u_wc, euw[i]);
            end
            checks++;
            if (u_reached !== eur[i]) begin
                failures++;
                $display("FAIL sat_u_reached[%0d] got=%b exp=%b", i, u_reached, eur[i]);
            end
            checks++;
            if (k_wc !== ekw[i]) begin
                failures++; $display("FAIL sat_k_wc[%0d] got=%0d exp=%0d", i, k_wc, ekw[i]);
            end
            checks++;
            if (u_overflow !== eov[i] || k_overflow !== 1'b0) begin
                failures++;
                $display("FAIL sat_overflow[%0d] got=%b/%b exp=%b/0", i, u_overflow, k_overflow,
                         eov[i]);
            end
            if (i == 5) begin
                qu = 5'd20;
                #1;
                checks++;
                if (u_reached !== 1'b0) begin
                    failures++; $display("FAIL sat_reached_q20 got=%b exp=0", u_reached);
                end
                qu = 5'd19;
            end
            step();
        end
        put(32'h0, 4'hF, 4'h0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (u_wc !== 5'd0 || u_overflow !== 1'b0) begin
            failures++; $display("FAIL sat_after_last got=%0d/%b exp=0/0", u_wc, u_overflow);
        end
        step();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_basic();
        test_backpressure();
        test_tuser_bytes();
        test_error();
        test_async_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
